control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Multi-cycle control unit; sits directly upstream of datapath and drives all of its control
//  inputs (pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl).
//  Sequences FETCH/DECODE/EXEC/MEM/WB from the fetched instr and the ALU status flags.
//  Also provides PC/IR enables, an illegal-instruction trap and a retired-instruction counter.
// PARAMETERS
//  TRAP_ON_ILLEGAL  1   1: illegal opcode -> TRAP state until rst; 0: treat as NOP, retire
//  CNT_W            32  width of retired-instruction counter
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  instr        in   32     instruction word from datapath IR (valid from DECODE onward)
//  status       in   5      ALU flags: [0] Z, [1] N, [2] C, [3] V, [4] reserved (ignored)
//  pcsrc        out  1      1 = PC <- branch target; only meaningful while pc_en=1
//  alusrc       out  1      1 = ALU B operand is immediate; 0 = rs2
//  aluop        out  4      0010 add, 0110 sub, 0000 and, 0001 or, 0011 xor, 0111 slt
//  memrw        out  1      1 = data-memory write strobe (one cycle)
//  wb           out  1      1 = register write data from memory; 0 = from ALU
//  regrw        out  1      register-file write strobe (one cycle)
//  immgen_ctrl  out  2      00 I-ALU, 01 I-load, 10 S, 11 B
//  pc_en        out  1      PC update strobe (one cycle per retired instruction)
//  ir_en        out  1      IR load strobe (FETCH only)
//  trap         out  1      high while in TRAP
//  retired      out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=FETCH, retired=0, trap=0; while rst=1 every strobe (ir_en, pc_en, regrw, memrw)
//    and pcsrc are 0, aluop=0010, alusrc=0, wb=0, immgen_ctrl=00. rst has priority over all.
//  States: FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}; TRAP is absorbing.
//  FETCH (1 cyc): ir_en=1. DECODE (1 cyc): register opcode/funct3/funct7 into decode reg.
//  Decode: 0110011 R (add,sub,and,or,xor,slt); 0010011 I-ALU (addi,andi,ori,xori,slti);
//    0000011 lw; 0100011 sw; 1100011 branch (beq,bne,blt,bge). Any other opcode/funct = illegal.
//  aluop/alusrc/immgen_ctrl/wb: driven from decode reg, held constant DECODE through last state.
//  R/I-ALU: EXEC -> WB; WB: regrw=1, wb=0, pc_en=1, pcsrc=0 -> FETCH. 4 cycles total.
//  lw: EXEC (add, alusrc=1, imm 01) -> MEM -> WB (regrw=1, wb=1, pc_en=1) -> FETCH. 5 cycles.
//  sw: EXEC (add, alusrc=1, imm 10) -> MEM (memrw=1, pc_en=1) -> FETCH. 4 cycles.
//  Branch: EXEC with aluop=0110, alusrc=0, imm 11; pc_en=1; pcsrc combinational from status
//    in EXEC: beq Z, bne !Z, blt N^V, bge !(N^V) -> FETCH. 3 cycles.
//  Illegal: detected in DECODE. TRAP_ON_ILLEGAL=1: next state TRAP (trap=1, all strobes 0,
//    no retire). TRAP_ON_ILLEGAL=0: DECODE -> FETCH with pc_en=1 in DECODE, counts as retired.
//  retired increments on the cycle after each pc_en=1; wraps to 0 after 2^CNT_W-1.
//  Strobes never asserted outside the listed state; never two of regrw/memrw in the same cycle.
//  rst mid-instruction: abandon it, no strobe that cycle, FETCH next; counter cleared.
//  status sampled only in branch EXEC; status[4] ignored everywhere.
// TESTING
//  rst 2 cyc, instr=add x3,x1,x2 (0x002081B3) -> ir_en c0, regrw+pc_en c3 only, aluop 0010, retired=1
//  beq (0x00208463) with status Z=1 -> EXEC: pcsrc=1, pc_en=1, aluop 0110; Z=0 -> pcsrc=0
//  lw (0x0000A183) -> 5-cycle seq, WB: regrw=1 wb=1 immgen 01; sw (0x0030A023) -> MEM memrw=1, regrw never 1
//  blt: status N=1,V=0 -> taken; N=1,V=1 -> not taken; bge inverse of each
//  instr=0xFFFFFFFF, TRAP_ON_ILLEGAL=1 -> trap=1 from c2, no strobes until rst; =0 -> pc_en in DECODE, retired+1
//  rst asserted in lw MEM -> next cycle FETCH, no regrw, retired=0; CNT_W=4: 16 retires -> wraps to 0

Source files
------------

// File: rtl/control_if.sv
// Control bundle between the multi-cycle control unit and the datapath.
// The control unit is the master; the datapath is the slave.
interface control_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic [4:0]       status;
  logic             pcsrc;
  logic             alusrc;
  logic [3:0]       aluop;
  logic             memrw;
  logic             wb;
  logic             regrw;
  logic [1:0]       immgen_ctrl;
  logic             pc_en;
  logic             ir_en;
  logic             trap;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, status,
    output pcsrc, alusrc, aluop, memrw, wb, regrw,
    output immgen_ctrl, pc_en, ir_en, trap, retired
  );

  modport slave (
    output instr, status,
    input  pcsrc, alusrc, aluop, memrw, wb, regrw,
    input  immgen_ctrl, pc_en, ir_en, trap, retired
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath controls,
// with illegal-opcode trap and a retired-instruction counter.
module control_fsm #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic      clk,
  input  logic      rst,
  control_if.master ctl
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    C_ALU, C_LD, C_ST, C_BR
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [2:0] f3;
    logic [3:0] aluop;
    logic       alusrc;
    logic [1:0] imm;
    logic       wb;
  } dec_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam dec_t DEC_NOP = '{
    cls: C_ALU, f3: 3'd0, aluop: 4'b0010,
    alusrc: 1'b0, imm: 2'b00, wb: 1'b0
  };

  state_t           r_state;
  dec_t             r_dec;
  logic [CNT_W-1:0] r_retired;

  dec_t       w_dec;
  dec_t       w_view;
  logic       w_ill;
  logic [4:0] w_alu;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_z, w_n, w_v;
  logic       w_taken;
  logic       w_pc_en, w_ir_en, w_regrw, w_memrw;
  logic       w_pcsrc, w_trap;
  logic       w_unused;

  // {valid, aluop} for the funct3 encodings shared by R and I-ALU
  function automatic logic [4:0] alu_f3(input logic [2:0] f3);
    unique case (f3)
      3'b000:  return 5'b1_0010;
      3'b111:  return 5'b1_0000;
      3'b110:  return 5'b1_0001;
      3'b100:  return 5'b1_0011;
      3'b010:  return 5'b1_0111;
      default: return 5'b0_0010;
    endcase
  endfunction

  assign w_op     = ctl.instr[6:0];
  assign w_f3     = ctl.instr[14:12];
  assign w_f7     = ctl.instr[31:25];
  assign w_z      = ctl.status[0];
  assign w_n      = ctl.status[1];
  assign w_v      = ctl.status[3];
  assign w_unused = ^{ctl.instr[24:15], ctl.instr[11:7],
                      ctl.status[4], ctl.status[2]};

  always_comb begin
    w_dec = DEC_NOP;
    w_ill = 1'b1;
    w_alu = alu_f3(w_f3);
    unique case (w_op)
      OP_R: begin
        if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_dec.aluop = 4'b0110;
          w_ill       = 1'b0;
        end else if (w_f7 == 7'b0000000) begin
          w_dec.aluop = w_alu[3:0];
          w_ill       = !w_alu[4];
        end
      end
      OP_I: begin
        w_dec.aluop  = w_alu[3:0];
        w_dec.alusrc = 1'b1;
        w_ill        = !w_alu[4];
      end
      OP_LD: begin
        w_dec.cls    = C_LD;
        w_dec.alusrc = 1'b1;
        w_dec.imm    = 2'b01;
        w_dec.wb     = 1'b1;
        w_ill        = (w_f3 != 3'b010);
      end
      OP_ST: begin
        w_dec.cls    = C_ST;
        w_dec.alusrc = 1'b1;
        w_dec.imm    = 2'b10;
        w_ill        = (w_f3 != 3'b010);
      end
      OP_BR: begin
        w_dec.cls   = C_BR;
        w_dec.f3    = w_f3;
        w_dec.aluop = 4'b0110;
        w_dec.imm   = 2'b11;
        w_ill       = !(w_f3 == 3'b000 || w_f3 == 3'b001 ||
                        w_f3 == 3'b100 || w_f3 == 3'b101);
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (r_dec.f3)
      3'b000:  w_taken = w_z;
      3'b001:  w_taken = !w_z;
      3'b100:  w_taken = w_n ^ w_v;
      3'b101:  w_taken = !(w_n ^ w_v);
      default: w_taken = 1'b0;
    endcase
  end

  // reset forces every output to its idle value in the same cycle
  always_comb begin
    w_view  = DEC_NOP;
    w_ir_en = 1'b0;
    w_pc_en = 1'b0;
    w_regrw = 1'b0;
    w_memrw = 1'b0;
    w_pcsrc = 1'b0;
    w_trap  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_FETCH:  w_ir_en = 1'b1;
        S_DECODE: begin
          w_view  = w_dec;
          w_pc_en = w_ill && !TRAP_ON_ILLEGAL;
        end
        S_EXEC: begin
          w_view  = r_dec;
          w_pc_en = (r_dec.cls == C_BR);
          w_pcsrc = (r_dec.cls == C_BR) && w_taken;
        end
        S_MEM: begin
          w_view  = r_dec;
          w_pc_en = (r_dec.cls == C_ST);
          w_memrw = (r_dec.cls == C_ST);
        end
        S_WB: begin
          w_view  = r_dec;
          w_pc_en = 1'b1;
          w_regrw = 1'b1;
        end
        S_TRAP:   w_trap = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_dec     <= DEC_NOP;
      r_retired <= '0;
    end else begin
      if (w_pc_en)
        r_retired <= r_retired + CNT_W'(1);
      unique case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_dec <= w_dec;
          if (w_ill)
            r_state <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          else
            r_state <= S_EXEC;
        end
        S_EXEC: begin
          unique case (r_dec.cls)
            C_BR:       r_state <= S_FETCH;
            C_LD, C_ST: r_state <= S_MEM;
            default:    r_state <= S_WB;
          endcase
        end
        S_MEM:
          r_state <= (r_dec.cls == C_LD) ? S_WB : S_FETCH;
        S_WB:     r_state <= S_FETCH;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  assign ctl.pcsrc       = w_pcsrc;
  assign ctl.alusrc      = w_view.alusrc;
  assign ctl.aluop       = w_view.aluop;
  assign ctl.memrw       = w_memrw;
  assign ctl.wb          = w_view.wb;
  assign ctl.regrw       = w_regrw;
  assign ctl.immgen_ctrl = w_view.imm;
  assign ctl.pc_en       = w_pc_en;
  assign ctl.ir_en       = w_ir_en;
  assign ctl.trap        = w_trap;
  assign ctl.retired     = r_retired;

endmodule

// File: tb/tb_control_fsm.sv
// Random + directed bench for control_fsm: one trapping 32-bit-counter
// instance and one non-trapping 4-bit-counter instance share stimulus.
module tb_control_fsm;

  typedef enum int { K_ALU, K_LD, K_ST, K_BR, K_ILL } kind_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         use_f7;
    kind_t      k;
    logic [7:0] ctl;
  } ent_t;

  logic clk;
  logic rst;

  control_if #(.CNT_W(32)) if0 ();
  control_if #(.CNT_W(4))  if1 ();

  control_fsm #(.TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)) dut0 (
    .clk (clk),
    .rst (rst),
    .ctl (if0.master)
  );

  control_fsm #(.TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .ctl (if1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  ent_t        tbl[17];
  logic [31:0] ills[6];
  logic [31:0] m0;
  logic [3:0]  m1;
  bit          trapped0;

  logic [4:0] o0, o1;
  logic [7:0] c0, c1;
  assign o0 = {if0.ir_en, if0.pc_en, if0.regrw, if0.memrw, if0.trap};
  assign o1 = {if1.ir_en, if1.pc_en, if1.regrw, if1.memrw, if1.trap};
  assign c0 = {if0.aluop, if0.alusrc, if0.immgen_ctrl, if0.wb};
  assign c1 = {if1.aluop, if1.alusrc, if1.immgen_ctrl, if1.wb};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input bit use_f7,
                              input kind_t k, input logic [7:0] ctl);
    ent_t e;
    e.op = op; e.f3 = f3; e.f7 = f7;
    e.use_f7 = use_f7; e.k = k; e.ctl = ctl;
    return e;
  endfunction

  // reference decoder: {aluop, alusrc, immgen, wb} from the ISA table
  task automatic lookup(input logic [31:0] ins, output kind_t k,
                        output logic [7:0] ctl);
    k   = K_ILL;
    ctl = 8'h20;
    foreach (tbl[i]) begin
      if (tbl[i].op == ins[6:0] && tbl[i].f3 == ins[14:12] &&
          (!tbl[i].use_f7 || tbl[i].f7 == ins[31:25])) begin
        k   = tbl[i].k;
        ctl = tbl[i].ctl;
      end
    end
  endtask

  function automatic bit taken(input logic [2:0] f3, input logic [4:0] st);
    bit z, n, v;
    z = st[0]; n = st[1]; v = st[3];
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n ^ v;
      3'b101:  return !(n ^ v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_strb0", 32'(o0), 32'h0);
    chk("rst_strb1", 32'(o1), 32'h0);
    chk("rst_pcsrc0", 32'(if0.pcsrc), 32'h0);
    chk("rst_ctl0", 32'(c0), 32'h20);
    chk("rst_ctl1", 32'(c1), 32'h20);
    @(posedge clk); #1;
    chk("rst_strb0b", 32'(o0), 32'h0);
    chk("rst_strb1b", 32'(o1), 32'h0);
    chk("rst_ret0", if0.retired, 32'h0);
    chk("rst_ret1", 32'(if1.retired), 32'h0);
    @(posedge clk); #1;
    rst      = 1'b0;
    m0       = '0;
    m1       = '0;
    trapped0 = 1'b0;
  endtask

  // runs one instruction from its FETCH cycle; abort_at >= 0 resets mid-way
  task automatic run_instr(input logic [31:0] ins, input logic [4:0] st,
                           input int abort_at);
    kind_t      k;
    logic [7:0] ctl;
    int         len;
    bit         last, tk;
    logic [4:0] e1, e0;
    lookup(ins, k, ctl);
    case (k)
      K_LD:    len = 5;
      K_BR:    len = 3;
      K_ILL:   len = 2;
      default: len = 4;
    endcase
    tk = taken(ins[14:12], st);
    if0.instr = ins; if1.instr = ins;
    if0.status = st; if1.status = st;
    for (int c = 0; c < len; c++) begin
      if (c == abort_at) begin
        do_reset();
        return;
      end
      #1;
      last = (c == len - 1);
      if (k == K_ILL)
        e1 = {c == 0, c == 1, 3'b000};
      else
        e1 = {c == 0, last, last && (k == K_ALU || k == K_LD),
              last && (k == K_ST), 1'b0};
      if (c == 0) chk("ret1", 32'(if1.retired), 32'(m1));
      chk("strb1", 32'(o1), 32'(e1));
      if (k == K_BR && last) chk("pcsrc1", 32'(if1.pcsrc), 32'(tk));
      if (k != K_ILL && c >= 1) chk("ctl1", 32'(c1), 32'(ctl));
      if (trapped0) begin
        chk("trap0", 32'(o0), 32'h1);
        if (c == 0) chk("ret0_trap", if0.retired, m0);
      end else begin
        e0 = (k == K_ILL) ? {c == 0, 4'b0000} : e1;
        if (c == 0) chk("ret0", if0.retired, m0);
        chk("strb0", 32'(o0), 32'(e0));
        if (k == K_BR && last) chk("pcsrc0", 32'(if0.pcsrc), 32'(tk));
        if (k != K_ILL && c >= 1) chk("ctl0", 32'(c0), 32'(ctl));
      end
      @(posedge clk); #1;
    end
    m1 = m1 + 4'd1;
    if (!trapped0) begin
      if (k == K_ILL) trapped0 = 1'b1;
      else            m0 = m0 + 32'd1;
    end
  endtask

  function automatic logic [31:0] rand_legal();
    ent_t e;
    logic [6:0] f7;
    e  = tbl[$urandom_range(0, 16)];
    f7 = e.use_f7 ? e.f7 : 7'($urandom);
    return {f7, 5'($urandom), 5'($urandom), e.f3, 5'($urandom), e.op};
  endfunction

  task automatic run_random(input int n, input int ill_pct);
    logic [31:0] ins;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < ill_pct)
        ins = ills[$urandom_range(0, 5)];
      else
        ins = rand_legal();
      run_instr(ins, 5'($urandom), -1);
    end
  endtask

  initial begin
    tbl[0]  = mk(7'b0110011, 3'b000, 7'b0000000, 1, K_ALU, 8'h20);
    tbl[1]  = mk(7'b0110011, 3'b000, 7'b0100000, 1, K_ALU, 8'h60);
    tbl[2]  = mk(7'b0110011, 3'b111, 7'b0000000, 1, K_ALU, 8'h00);
    tbl[3]  = mk(7'b0110011, 3'b110, 7'b0000000, 1, K_ALU, 8'h10);
    tbl[4]  = mk(7'b0110011, 3'b100, 7'b0000000, 1, K_ALU, 8'h30);
    tbl[5]  = mk(7'b0110011, 3'b010, 7'b0000000, 1, K_ALU, 8'h70);
    tbl[6]  = mk(7'b0010011, 3'b000, 7'b0, 0, K_ALU, 8'h28);
    tbl[7]  = mk(7'b0010011, 3'b111, 7'b0, 0, K_ALU, 8'h08);
    tbl[8]  = mk(7'b0010011, 3'b110, 7'b0, 0, K_ALU, 8'h18);
    tbl[9]  = mk(7'b0010011, 3'b100, 7'b0, 0, K_ALU, 8'h38);
    tbl[10] = mk(7'b0010011, 3'b010, 7'b0, 0, K_ALU, 8'h78);
    tbl[11] = mk(7'b0000011, 3'b010, 7'b0, 0, K_LD, 8'h2B);
    tbl[12] = mk(7'b0100011, 3'b010, 7'b0, 0, K_ST, 8'h2C);
    tbl[13] = mk(7'b1100011, 3'b000, 7'b0, 0, K_BR, 8'h66);
    tbl[14] = mk(7'b1100011, 3'b001, 7'b0, 0, K_BR, 8'h66);
    tbl[15] = mk(7'b1100011, 3'b100, 7'b0, 0, K_BR, 8'h66);
    tbl[16] = mk(7'b1100011, 3'b101, 7'b0, 0, K_BR, 8'h66);

    ills[0] = 32'hFFFFFFFF;
    ills[1] = 32'h022081B3;
    ills[2] = 32'h00209193;
    ills[3] = 32'h0000B183;
    ills[4] = 32'h0020A463;
    ills[5] = 32'h0000007F;

    rst = 1'b1;
    if0.instr = '0; if1.instr = '0;
    if0.status = '0; if1.status = '0;
    m0 = '0; m1 = '0; trapped0 = 1'b0;
    do_reset();

    run_instr(32'h002081B3, 5'b00000, -1);
    run_instr(32'h00208463, 5'b00001, -1);
    run_instr(32'h00208463, 5'b00000, -1);
    run_instr(32'h00208463, 5'b10001, -1);
    run_instr(32'h0000A183, 5'b00000, -1);
    run_instr(32'h0030A023, 5'b00000, -1);
    run_instr(32'h0020C463, 5'b00010, -1);
    run_instr(32'h0020C463, 5'b01010, -1);
    run_instr(32'h0020D463, 5'b00010, -1);
    run_instr(32'h0020D463, 5'b01010, -1);
    run_instr(32'h00209463, 5'b00001, -1);

    run_random(40, 0);
    run_instr(32'h0000A183, 5'b00000, 3);
    run_instr(32'h002081B3, 5'b00000, -1);
    run_random(20, 0);

    run_instr(32'hFFFFFFFF, 5'b00000, -1);
    run_random(30, 25);

    do_reset();
    run_instr(32'h002081B3, 5'b00000, -1);
    run_random(20, 0);
    run_instr(ills[$urandom_range(1, 5)], 5'b00000, -1);
    run_random(20, 30);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
